sram_1rw1r_ctrl: RTL
====================

# sram_1rw1r_ctrl

Parametrised request/response front-end for a single 1RW+1R SRAM macro; next generation of the single-port SRAM top wrapper. Exposes both macro ports (A: read/write, B: read-only) as independent valid/ready channels with per-port response buffering and backpressure. Resolves same-cycle A-write/B-read address collisions. Sits between core-side masters and the hard macro; macro pins are driven as block outputs.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 8, word address width (DEPTH = 2**ADDR_W)
- RSP_DEPTH, 2, per-port response FIFO entries, including in-flight reads; ≥2
- clk  in  1  single clock; macro also runs on clk
- reset  in  1  synchronous, active-high
- a_req_valid_i / a_req_ready_o  in/out  1  port A request handshake
- a_req_we_i  in  1  1 = write, 0 = read
- a_req_wmask_i  in  DATA_W/8  byte enables; writes only
- a_req_addr_i  in  ADDR_W  word address
- a_req_wdata_i  in  DATA_W  write data
- a_rsp_valid_o / a_rsp_ready_i  out/in  1  port A read-response handshake
- a_rsp_rdata_o  out  DATA_W  port A read data
- b_req_valid_i / b_req_ready_o  in/out  1  port B read-request handshake
- b_req_addr_i  in  ADDR_W  port B address
- b_rsp_valid_o / b_rsp_ready_i  out/in  1  port B response handshake
- b_rsp_rdata_o  out  DATA_W  port B read data
- sram_csb0_o, sram_web0_o  out  1  macro port 0 select / write, active-low
- sram_wmask0_o  out  DATA_W/8; sram_addr0_o  out  ADDR_W; sram_din0_o  out  DATA_W
- sram_dout0_i  in  DATA_W  macro port 0 read data
- sram_csb1_o  out  1; sram_addr1_o  out  ADDR_W; sram_dout1_i  in  DATA_W  macro port 1

## Operation
- Request accepted when valid & ready in the same cycle. Macro pins are combinational from the accepted request: csb low, web = ~we, addr/din/wmask pass through. No accept: csb0/csb1 = 1, web0 = 1, other pins = 0.
- Writes produce no response. A write is accepted whenever a_req_valid_i = 1 and reset = 0; it needs no FIFO credit.
- Reads on each port: per-port occupancy counter occ = in-flight reads + FIFO entries, range 0..RSP_DEPTH.
  - Read ready = (occ < RSP_DEPTH) | (rsp_valid & rsp_ready). The combinational path from rsp_ready to req_ready is intentional.
  - occ +1 on read accept and -1 on response pop. Simultaneous accept and pop leaves occ unchanged.
- Read data: macro dout is sampled the cycle after accept and pushed into the port FIFO. FIFO is first-in first-out; responses return in request order per port.
- rsp_valid = FIFO non-empty; rdata = FIFO head. Both are held stable while rsp_ready = 0.
- Collision: port A write accepted and port B read to the same address in the same cycle. Behaviour is set by the configuration macro below.
- Reset:
  - Clears occ, FIFO pointers and any in-flight read marker; in-flight data is dropped.
  - During reset: req_ready = 0, rsp_valid = 0, csb0 = csb1 = 1, web0 = 1.
  - Applies identically when asserted mid-operation; no response from a pre-reset request ever appears.

## Timing
- Read latency: accept in cycle N, macro dout captured at edge ending N+1, rsp_valid = 1 in N+2.
- Throughput: one read per cycle per port sustained with rsp_ready held 1 and RSP_DEPTH ≥ 2.
- Write takes effect at the edge ending the accept cycle. A port A read accepted in the next cycle returns the new data.
- Ports A and B are fully independent apart from the collision rule.

## Configuration
- SRAM_CTRL_COLLISION_FWD_EN defined:
  - Port B read proceeds in the collision cycle.
  - Block registers the write data and mask, and merges the written bytes over sram_dout1_i at capture.
  - B returns post-write data with no stall.
- SRAM_CTRL_COLLISION_FWD_EN undefined:
  - b_req_ready_o = 0 in the collision cycle; B read is deferred one cycle and returns post-write data.
  - Port A is never stalled.

## Test plan
- Write 0xDEADBEEF at addr 0x10 mask 0xF, then A read at 0x10 -> a_rsp_valid in 2 cycles, rdata 0xDEADBEEF.
- Write 0x11223344 mask 0xF, then 0xAABBCCDD mask 0x5 to addr 0x20, then read -> 0x11BB33DD.
- Back-to-back B reads of addrs 0..7 with b_rsp_ready = 1 -> one response per cycle, in order, no ready drop.
- Hold a_rsp_ready = 0 and issue 3 A reads -> only RSP_DEPTH = 2 accepted, ready low, rdata stable. Release -> drains in order, third accepted.
- Same cycle: A write 0xCAFEF00D to addr 0x30 and B read addr 0x30 -> B returns 0xCAFEF00D. With the macro defined: no stall. Without it: b_req_ready low for 1 cycle.
- Assert reset for 1 cycle with 2 reads in flight -> no responses emerge, occ = 0, csb0 = csb1 = 1, ready = 1 in the first cycle after reset.

Source files
------------

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: valid/ready front-end for a 1RW+1R SRAM macro.
// Port A (read/write) drives macro port 0. Port B (read-only) drives macro port 1.
// Each port owns a small response FIFO. Its occupancy counter also covers the
// read still in the macro pipeline, so a captured word always has a free slot.
// Optional feature macro: SRAM_CTRL_COLLISION_FWD_EN.
//   Defined:   a port B read to the address port A writes in the same cycle
//              proceeds, and the written bytes are merged into B's data.
//   Undefined: that B read is held off for one cycle instead.
module sram_1rw1r_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req_valid_i,
  output logic                a_req_ready_o,
  input  logic                a_req_we_i,
  input  logic [DATA_W/8-1:0] a_req_wmask_i,
  input  logic [ADDR_W-1:0]   a_req_addr_i,
  input  logic [DATA_W-1:0]   a_req_wdata_i,
  output logic                a_rsp_valid_o,
  input  logic                a_rsp_ready_i,
  output logic [DATA_W-1:0]   a_rsp_rdata_o,
  input  logic                b_req_valid_i,
  output logic                b_req_ready_o,
  input  logic [ADDR_W-1:0]   b_req_addr_i,
  output logic                b_rsp_valid_o,
  input  logic                b_rsp_ready_i,
  output logic [DATA_W-1:0]   b_rsp_rdata_o,
  output logic                sram_csb0_o,
  output logic                sram_web0_o,
  output logic [DATA_W/8-1:0] sram_wmask0_o,
  output logic [ADDR_W-1:0]   sram_addr0_o,
  output logic [DATA_W-1:0]   sram_din0_o,
  input  logic [DATA_W-1:0]   sram_dout0_i,
  output logic                sram_csb1_o,
  output logic [ADDR_W-1:0]   sram_addr1_o,
  input  logic [DATA_W-1:0]   sram_dout1_i
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OCC_W  = $clog2(RSP_DEPTH + 1);

  // Index 0 is port A, index 1 is port B.
  logic                   a_acc;
  logic                   a_wr_acc;
  logic                   a_rd_acc;
  logic                   b_rd_acc;
  logic [1:0]             rd_acc;
  logic [1:0]             rd_room;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [1:0][DATA_W-1:0] cap_data;
  logic [1:0][DATA_W-1:0] rsp_rdata;
  logic [DATA_W-1:0]      b_cap_data;

  // Writes never need response credit, so they are only blocked by reset.
  assign a_req_ready_o = ~reset & (a_req_we_i | rd_room[0]);
  assign a_acc         = a_req_valid_i & a_req_ready_o;
  assign a_wr_acc      = a_acc & a_req_we_i;
  assign a_rd_acc      = a_acc & ~a_req_we_i;
  assign b_rd_acc      = b_req_valid_i & b_req_ready_o;

`ifdef SRAM_CTRL_COLLISION_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [MASK_W-1:0] fwd_mask;

  assign b_req_ready_o = ~reset & rd_room[1];

  // Remember a same-address A write so its bytes can override B's capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit <= 1'b0;
    end else begin
      fwd_hit <= b_rd_acc & a_wr_acc & (a_req_addr_i == b_req_addr_i);
    end
    fwd_data <= a_req_wdata_i;
    fwd_mask <= a_req_wmask_i;
  end

  // Overlay the forwarded write bytes on the macro's pre-write port 1 data.
  always_comb begin
    b_cap_data = sram_dout1_i;
    for (int i = 0; i < MASK_W; i++) begin
      if (fwd_hit && fwd_mask[i]) begin
        b_cap_data[8*i +: 8] = fwd_data[8*i +: 8];
      end
    end
  end
`else
  assign b_req_ready_o = ~reset & rd_room[1] &
                         ~(a_wr_acc & (a_req_addr_i == b_req_addr_i));
  assign b_cap_data    = sram_dout1_i;
`endif

  assign rd_acc      = {b_rd_acc, a_rd_acc};
  assign rsp_ready   = {b_rsp_ready_i, a_rsp_ready_i};
  assign cap_data[0] = sram_dout0_i;
  assign cap_data[1] = b_cap_data;

  assign a_rsp_valid_o = rsp_valid[0];
  assign a_rsp_rdata_o = rsp_rdata[0];
  assign b_rsp_valid_o = rsp_valid[1];
  assign b_rsp_rdata_o = rsp_rdata[1];

  // Macro pins follow the accepted request and idle at zero otherwise.
  assign sram_csb0_o   = ~a_acc;
  assign sram_web0_o   = ~a_wr_acc;
  assign sram_addr0_o  = a_acc    ? a_req_addr_i  : '0;
  assign sram_din0_o   = a_wr_acc ? a_req_wdata_i : '0;
  assign sram_wmask0_o = a_wr_acc ? a_req_wmask_i : '0;
  assign sram_csb1_o   = ~b_rd_acc;
  assign sram_addr1_o  = b_rd_acc ? b_req_addr_i  : '0;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  fifo_cnt;
    logic [OCC_W-1:0]  occ;
    logic              inflight;
    logic              pop;

    assign rsp_valid[p] = ~reset & (fifo_cnt != '0);
    assign rsp_rdata[p] = fifo_mem[rd_ptr];
    assign pop          = rsp_valid[p] & rsp_ready[p];
    assign rd_room[p]   = (occ < OCC_W'(RSP_DEPTH)) | pop;

    // Capture macro data one cycle after accept and track response credit.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
        occ      <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= rd_acc[p];
        if (inflight) begin
          fifo_mem[wr_ptr] <= cap_data[p];
          wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        fifo_cnt <= fifo_cnt + OCC_W'(inflight) - OCC_W'(pop);
        occ      <= occ + OCC_W'(rd_acc[p]) - OCC_W'(pop);
      end
    end
  end

endmodule
